// File: rtl/approx_error_monitor.sv
// Measures error statistics of an approximate 16-bit adder against the exact sum
// over a run of N_SAMPLES operand/result samples, using a two-stage pipeline.
module approx_error_monitor #(
    parameter int N_SAMPLES = 1024,
    parameter int ACC_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      A,
    input  logic [15:0]      B,
    input  logic             Carry_in,
    input  logic [15:0]      Sum,
    input  logic             Carry_Out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      err_count,
    output logic [16:0]      max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic             sat
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

    localparam logic [16:0] N_LIM = 17'(N_SAMPLES);

    state_t            r_state, w_state_next;
    logic [16:0]       r_cnt;
    logic              r_drain;
    logic              r_done;
    logic              r_s1_valid;
    logic [16:0]       r_s1_ed;
    logic [15:0]       r_err_count;
    logic [16:0]       r_max_ed;
    logic [ACC_W-1:0]  r_sum_ed;
    logic              r_sat;

    logic              w_start_run;
    logic              w_accept;
    logic              w_last;
    logic [16:0]       w_exact;
    logic [16:0]       w_approx;
    logic [16:0]       w_ed;
    logic [ACC_W:0]    w_sum_ext;
    logic              w_sum_sat;

    assign w_start_run = start && (r_state == IDLE || r_state == DONE_ST);
    assign in_ready    = (r_state == RUN) && (r_cnt < N_LIM);
    assign w_accept    = in_valid && in_ready;
    assign w_last      = w_accept && (r_cnt == N_LIM - 17'd1);

    assign w_exact  = {1'b0, A} + {1'b0, B} + {16'b0, Carry_in};
    assign w_approx = {Carry_Out, Sum};
    assign w_ed     = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);

    // One extra bit catches the accumulator overflow so it can be clamped.
    assign w_sum_ext = {1'b0, r_sum_ed} + (ACC_W+1)'(r_s1_ed);
    assign w_sum_sat = w_sum_ext[ACC_W] || (&w_sum_ext[ACC_W-1:0]);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE_ST: if (start)   w_state_next = RUN;
            RUN:           if (w_last)  w_state_next = DRAIN;
            DRAIN:         if (r_drain) w_state_next = DONE_ST;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drain <= (r_state == DRAIN) && !r_drain;
            r_done  <= (r_state == DRAIN) && (w_state_next == DONE_ST);
            if (w_start_run)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= r_cnt + 17'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept)
                r_s1_ed <= w_ed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_sum_ed    <= '0;
            r_sat       <= 1'b0;
        end else if (w_start_run) begin
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_sum_ed    <= '0;
            r_sat       <= 1'b0;
        end else if (r_s1_valid) begin
            if (r_s1_ed != 17'd0 && r_err_count != 16'hFFFF)
                r_err_count <= r_err_count + 16'd1;
            if (r_s1_ed > r_max_ed)
                r_max_ed <= r_s1_ed;
            if (w_sum_ext[ACC_W])
                r_sum_ed <= {ACC_W{1'b1}};
            else
                r_sum_ed <= w_sum_ext[ACC_W-1:0];
            if (w_sum_sat)
                r_sat <= 1'b1;
        end
    end

    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = r_done;
    assign err_count = r_err_count;
    assign max_ed    = r_max_ed;
    assign sum_ed    = r_sum_ed;
    assign sat       = r_sat;
endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench: three monitor instances (N=1, N=3, N=4 with a 17-bit
// accumulator) share the sample bus; each has its own start pulse.
module tb_approx_error_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0, b = '0, s = '0;
    logic        ci = 1'b0, co = 1'b0;

    logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2, sat0, sat1, sat2;
    logic [15:0] err0, err1, err2;
    logic [16:0] max0, max1, max2;
    logic [31:0] sum0, sum1;
    logic [16:0] sum2;

    int          sel = 0;
    logic        m_rdy, m_busy, m_done, m_sat;
    logic [15:0] m_err;
    logic [16:0] m_max;
    logic [31:0] m_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_error_monitor #(.N_SAMPLES(1), .ACC_W(32)) u_n1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy0),
        .A(a), .B(b), .Carry_in(ci), .Sum(s), .Carry_Out(co), .busy(busy0), .done(done0),
        .err_count(err0), .max_ed(max0), .sum_ed(sum0), .sat(sat0));

    approx_error_monitor #(.N_SAMPLES(3), .ACC_W(32)) u_n3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy1),
        .A(a), .B(b), .Carry_in(ci), .Sum(s), .Carry_Out(co), .busy(busy1), .done(done1),
        .err_count(err1), .max_ed(max1), .sum_ed(sum1), .sat(sat1));

    approx_error_monitor #(.N_SAMPLES(4), .ACC_W(17)) u_n4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy2),
        .A(a), .B(b), .Carry_in(ci), .Sum(s), .Carry_Out(co), .busy(busy2), .done(done2),
        .err_count(err2), .max_ed(max2), .sum_ed(sum2), .sat(sat2));

    always_comb begin
        m_rdy = rdy2; m_busy = busy2; m_done = done2; m_sat = sat2;
        m_err = err2; m_max = max2; m_sum = {15'b0, sum2};
        case (sel)
            0: begin
                m_rdy = rdy0; m_busy = busy0; m_done = done0; m_sat = sat0;
                m_err = err0; m_max = max0; m_sum = sum0;
            end
            1: begin
                m_rdy = rdy1; m_busy = busy1; m_done = done1; m_sat = sat1;
                m_err = err1; m_max = max1; m_sum = sum1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_v[sel] = 1'b1;
        tick();
        start_v = '0;
    endtask

    task automatic set_sample(input logic [15:0] ta, input logic [15:0] tb_,
                              input logic tci, input logic [15:0] ts, input logic tco);
        a = ta; b = tb_; ci = tci; s = ts; co = tco;
    endtask

    // Offers one sample for one clock edge; in_valid stays high for back-to-back use.
    task automatic put(input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tci, input logic [15:0] ts, input logic tco);
        set_sample(ta, tb_, tci, ts, tco);
        in_valid = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, m_done, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},  m_rdy,  1'b0);
        chk({tag, "_busy"}, m_busy, 1'b0);
        chk({tag, "_done"}, m_done, 1'b0);
        chk({tag, "_err"},  m_err,  16'd0);
        chk({tag, "_max"},  m_max,  17'd0);
        chk({tag, "_sum"},  m_sum,  32'd0);
        chk({tag, "_sat"},  m_sat,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ta[4], tbv[4], ts[4];
        logic        tco[4], tci[4];
        int acc, last_acc, done_at, ndone;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        sel = 2;
        chk_zero("reset");
        $display("test reset_state done");

        // Single sample: exact 8, approx 6 -> ed 2
        sel = 0;
        pulse_start();
        chk("n1_ready", m_rdy, 1'b1);
        chk("n1_busy", m_busy, 1'b1);
        put(16'd5, 16'd3, 1'b0, 16'h0006, 1'b0);
        in_valid = 1'b0;
        chk("n1_ready_drop", m_rdy, 1'b0);
        chk("n1_done_c1", m_done, 1'b0);
        tick();
        chk("n1_done_c2", m_done, 1'b0);
        tick();
        chk("n1_done_c3", m_done, 1'b1);
        chk("n1_err", m_err, 16'd1);
        chk("n1_max", m_max, 17'd2);
        chk("n1_sum", m_sum, 32'd2);
        chk("n1_busy_end", m_busy, 1'b0);
        tick();
        chk("n1_done_pulse", m_done, 1'b0);
        chk("n1_hold_sum", m_sum, 32'd2);
        $display("test single_sample done");

        // start together with in_valid: that sample (ed 5) must be dropped
        set_sample(16'd10, 16'd0, 1'b0, 16'd5, 1'b0);
        in_valid = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v = '0;
        in_valid = 1'b0;
        tick();
        put(16'd1, 16'd1, 1'b0, 16'd3, 1'b0);
        in_valid = 1'b0;
        wait_done("same_cycle_done", 10);
        chk("same_cycle_max", m_max, 17'd1);
        chk("same_cycle_sum", m_sum, 32'd1);
        $display("test start_with_valid done");

        // Four exact samples, including carry-out cases
        sel = 2;
        pulse_start();
        put(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        put(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0);
        put(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        put(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
        in_valid = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_done) ndone++;
        end
        chk("exact_done_pulses", ndone, 1);
        chk("exact_err", m_err, 16'd0);
        chk("exact_max", m_max, 17'd0);
        chk("exact_sum", m_sum, 32'd0);
        $display("test exact_samples done");

        // Saturation of a 17-bit accumulator: 4 x 0x10000
        pulse_start();
        for (int i = 0; i < 4; i++) put(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        in_valid = 1'b0;
        wait_done("sat_done", 10);
        chk("sat_sum", m_sum, 32'h1FFFF);
        chk("sat_flag", m_sat, 1'b1);
        chk("sat_max", m_max, 17'h10000);
        chk("sat_err", m_err, 16'd4);
        tick();
        chk("sat_hold", m_sat, 1'b1);
        $display("test saturation done");

        // start pulsed mid-run must be ignored
        pulse_start();
        put(16'd1, 16'd1, 1'b0, 16'd3, 1'b0);
        in_valid = 1'b0;
        chk("midstart_sat_cleared", m_sat, 1'b0);
        pulse_start();
        chk("midstart_err_kept", m_err, 16'd1);
        chk("midstart_busy", m_busy, 1'b1);
        for (int i = 0; i < 3; i++) put(16'd5, 16'd3, 1'b0, 16'd6, 1'b0);
        in_valid = 1'b0;
        wait_done("midstart_done", 10);
        chk("midstart_err", m_err, 16'd4);
        chk("midstart_sum", m_sum, 32'd7);
        chk("midstart_max", m_max, 17'd2);
        $display("test start_in_run done");

        // Gappy in_valid, N=3: eds 0, 7, 3, and a 4th (0x10000) that must be refused
        sel = 1;
        ta  = '{16'hFFFF, 16'd10, 16'h8000, 16'hFFFF};
        tbv = '{16'h0001, 16'd0,  16'h8000, 16'h0001};
        tci = '{1'b0, 1'b1, 1'b0, 1'b0};
        ts  = '{16'h0000, 16'd4,  16'h0003, 16'h0000};
        tco = '{1'b1, 1'b0, 1'b1, 1'b0};
        pulse_start();
        acc = 0; last_acc = -10; done_at = -1; ndone = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = (i % 2 == 0);
            set_sample(ta[acc < 3 ? acc : 3], tbv[acc < 3 ? acc : 3], tci[acc < 3 ? acc : 3],
                       ts[acc < 3 ? acc : 3], tco[acc < 3 ? acc : 3]);
            if (in_valid && m_rdy) begin
                acc++;
                last_acc = i;
            end
            tick();
            if (m_done) begin
                ndone++;
                done_at = i;
            end
        end
        in_valid = 1'b0;
        chk("gap_accepted", acc, 3);
        chk("gap_done_lat", done_at - last_acc, 2);
        chk("gap_done_pulses", ndone, 1);
        chk("gap_ready_low", m_rdy, 1'b0);
        chk("gap_err", m_err, 16'd2);
        chk("gap_max", m_max, 17'd7);
        chk("gap_sum", m_sum, 32'd10);
        $display("test gappy_valid done");

        // Reset mid-run, then a clean run of 4 x ed=1
        sel = 2;
        pulse_start();
        put(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        put(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) put(16'd1, 16'd1, 1'b0, 16'd3, 1'b0);
        in_valid = 1'b0;
        wait_done("rerun_done", 10);
        chk("rerun_err", m_err, 16'd4);
        chk("rerun_sum", m_sum, 32'd4);
        chk("rerun_max", m_max, 17'd1);
        chk("rerun_sat", m_sat, 1'b0);
        $display("test reset_mid_run done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1024, meaning the number of operand/result samples per measurement run (legal range 1..65535).
REQ-002 SHALL have parameter ACC_W, default 32, meaning the width of the error-distance accumulator.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a run.
REQ-006 SHALL have port in_valid, input, 1, meaning the sample on A/B/Carry_in/Sum/Carry_Out is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts the sample this cycle.
REQ-008 SHALL have port A, input, 16, the adder operand A.
REQ-009 SHALL have port B, input, 16, the adder operand B.
REQ-010 SHALL have port Carry_in, input, 1, the adder carry-in.
REQ-011 SHALL have port Sum, input, 16, the approximate adder sum.
REQ-012 SHALL have port Carry_Out, input, 1, the approximate adder bit-16 carry.
REQ-013 SHALL have port busy, output, 1, high while a run is active.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse marking that results are final.
REQ-015 SHALL have port err_count, output, 16, the number of samples with nonzero error distance.
REQ-016 SHALL have port max_ed, output, 17, the largest error distance seen in the run.
REQ-017 SHALL have port sum_ed, output, ACC_W, the accumulated error distance, saturating.
REQ-018 SHALL have port sat, output, 1, a sticky flag that sum_ed has saturated during the run.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, and DONE_ST.
REQ-020 IDLE/DONE_ST: on start, SHALL clear err_count, max_ed, sum_ed, sat and the sample counter, then enter RUN.
REQ-021 RUN: in_ready SHALL equal 1 when accepted < N_SAMPLES; a sample SHALL be accepted on in_valid && in_ready.
REQ-022 RUN -> DRAIN SHALL occur on the cycle the N_SAMPLES-th sample is accepted; in_ready SHALL be 0 in all states except RUN.
REQ-023 DRAIN -> DONE_ST SHALL occur once the pipeline is empty (2 cycles); done SHALL pulse for exactly 1 cycle on entry to DONE_ST.
REQ-024 start SHALL be ignored in RUN and DRAIN.
REQ-025 busy SHALL be 1 in RUN and DRAIN.
REQ-026 Stage 1 (accept cycle + 1): SHALL register exact = A + B + Carry_in (17 bit), approx = {Carry_Out, Sum}, and ed = |exact - approx| (17 bit unsigned), with valid.
REQ-027 Stage 2 (accept cycle + 2): if ed != 0, err_count SHALL increment; max_ed SHALL become max(max_ed, ed); sum_ed SHALL become sum_ed + ed.
REQ-028 sum_ed SHALL saturate at 2^ACC_W - 1 instead of wrapping; sat SHALL set at saturation and hold until the next start.
REQ-029 err_count SHALL saturate at 0xFFFF.
REQ-030 Outputs SHALL hold their values in DONE_ST and IDLE until the next start; gaps in in_valid SHALL stall nothing but sample intake.
REQ-031 If start and in_valid occur in the same IDLE cycle, the sample SHALL NOT be accepted.

Reset
REQ-032 Asserting rst at any time, including mid-run, SHALL force IDLE, clear the pipeline, and zero all outputs (in_ready=0, busy=0, done=0, err_count=0, max_ed=0, sum_ed=0, sat=0).
REQ-033 No sample accepted before reset SHALL affect any output after reset is released.

Verification
REQ-034 With N_SAMPLES=1, start, then A=5, B=3, Carry_in=0, Sum=0x0006, Carry_Out=0 -> done 3 cycles after acceptance; err_count=1, max_ed=2, sum_ed=2.
REQ-035 With N_SAMPLES=4 and 4 exact samples (Sum=A+B, e.g. 0xFFFF+0x0001 -> Sum=0, Carry_Out=1) -> err_count=0, max_ed=0, sum_ed=0, one done pulse.
REQ-036 With ACC_W=17, N_SAMPLES=4, and each sample ed=0x10000 (A=0xFFFF, B=0x0001, Carry_in=0, Sum=0, Carry_Out=0) -> sum_ed=0x1FFFF, sat=1, max_ed=0x10000.
REQ-037 With in_valid toggling every other cycle, N_SAMPLES=3 -> exactly 3 samples accepted, in_ready drops after the third, done follows 2 cycles later.
REQ-038 With rst asserted after 2 of 4 samples, then a new start and 4 samples with ed=1 -> err_count=4, sum_ed=4.
REQ-039 With start pulsed during RUN -> no counters are cleared and the run completes normally.
